// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register bank: FSM states and
// byte/ACK bit positions used when framing bytes on the raw bus.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_PTR,
    WR,
    RD,
    IGNORE
  } i2c_state_t;

  localparam int I2C_BYTE_BITS = 8;
  localparam int I2C_ACK_BIT   = 8;

endpackage

// File: rtl/i2c_register_bank_if.sv
// Bus-side bundle between the register bank and its companion i2c_peripheral:
// raw line taps plus the peripheral's rx/rw outputs and tx input.
interface i2c_register_bank_if;

  logic       scl;
  logic       sda;
  logic [7:0] rx;
  logic       rw;
  logic [7:0] tx;

  modport master (output scl, sda, rx, rw, input tx);
  modport slave  (input scl, sda, rx, rw, output tx);

endinterface

// File: rtl/i2c_line_sync.sv
// Brings raw SCL/SDA into the system clock domain and flags SCL edges and
// START/STOP conditions as single-cycle pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  // Bit 0/1 form the synchroniser, bit 2 holds the previous synchronised level.
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sda_o      = sda_q[1];

endmodule

// File: rtl/i2c_register_bank.sv
// System-clock register file behind i2c_peripheral: frames bus transactions
// from oversampled SCL/SDA and exposes the bank to fabric logic.
module i2c_register_bank
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS  = 7'h42,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic [7:0]       rx_i,
  input  logic             rw_i,
  output logic [7:0]       tx_o,
  input  logic             hw_we_i,
  input  logic [PTR_W-1:0] hw_addr_i,
  input  logic [7:0]       hw_wdata_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic             wr_strobe_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic             busy_o
);

  logic scl_rise, scl_fall, start, stop, sda;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop),
    .sda_o     (sda)
  );

  i2c_state_t               state_q, state_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic [I2C_BYTE_BITS-1:0] shreg_q, shreg_d;
  logic                     ack_pend_q, ack_pend_d;
  logic                     busy_q, busy_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [7:0]               regs_q [NUM_REGS];
  logic [7:0]               regs_d [NUM_REGS];
  logic                     i2c_we;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ack_pend_d  = ack_pend_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    i2c_we      = 1'b0;

    if (stop) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      bitcnt_d   = '0;
      ack_pend_d = 1'b0;
    end else if (start) begin
      state_d    = ADDR;
      bitcnt_d   = '0;
      ack_pend_d = 1'b0;
    end else if (state_q != IDLE && state_q != IGNORE) begin
      if (scl_rise) begin
        if (bitcnt_q == 4'(I2C_ACK_BIT)) begin
          bitcnt_d = '0;
          case (state_q)
            ADDR: begin
              if (shreg_q[I2C_BYTE_BITS-1:1] == ADDRESS && rw_i == shreg_q[0]) begin
                state_d = shreg_q[0] ? RD : WR_PTR;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
            WR_PTR, WR: ack_pend_d = 1'b1;
            // Controller ACK or NACK both advance the read pointer.
            RD:         ptr_d = ptr_q + PTR_W'(1);
            default:    ;
          endcase
        end else begin
          shreg_d  = {shreg_q[I2C_BYTE_BITS-2:0], sda};
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end else if (scl_fall && ack_pend_q) begin
        // rx_i from the peripheral is stable once the ACK clock has ended.
        ack_pend_d = 1'b0;
        if (state_q == WR_PTR) begin
          ptr_d   = rx_i[PTR_W-1:0];
          state_d = WR;
        end else begin
          i2c_we      = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = ptr_q;
          ptr_d       = ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // The I2C write is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (hw_we_i) regs_d[hw_addr_i] = hw_wdata_i;
    if (i2c_we)  regs_d[ptr_q]     = rx_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      ack_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ack_pend_q  <= ack_pend_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // NOTE: the bank is small and flop-based, so it is reset like any other state;
  // a RAM-inferred array would be left unreset instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: 8'h00};
    else        regs_q <= regs_d;
  end

  assign tx_o        = regs_q[ptr_q];
  assign rd_data_o   = regs_q[rd_addr_i];
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Directed bench for i2c_register_bank: drives raw SCL/SDA plus the
// peripheral's rx/rw, and scores every write and read-port value against a model.
module tb_i2c_register_bank;

  localparam logic [6:0] ADDR = 7'h42;
  localparam int         Q    = 4;   // quarter SCL period in clk cycles

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hw_we;
  logic [3:0] hw_addr;
  logic [7:0] hw_wdata;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       busy;

  i2c_register_bank_if bus ();

  i2c_register_bank #(.ADDRESS(ADDR), .NUM_REGS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (bus.scl),
    .sda_i      (bus.sda),
    .rx_i       (bus.rx),
    .rw_i       (bus.rw),
    .tx_o       (bus.tx),
    .hw_we_i    (hw_we),
    .hw_addr_i  (hw_addr),
    .hw_wdata_i (hw_wdata),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .wr_strobe_o(wr_strobe),
    .wr_addr_o  (wr_addr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: register contents plus the queue of I2C writes the frames must produce.
  logic [7:0] m_regs [16];
  wr_t        exp_q [$];
  wr_t        cmp_e;
  int         strobe_cnt = 0;
  logic [3:0] coll_addr;
  logic [7:0] coll_data;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (wr_strobe) begin
        strobe_cnt++;
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cmp_e = exp_q.pop_front();
          check("strobe_addr", 32'(wr_addr), 32'(cmp_e.addr));
          m_regs[cmp_e.addr] = cmp_e.data;
        end
      end
      check("rd_data", 32'(rd_data), 32'(m_regs[rd_addr]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock; with coll set, a fabric write is timed onto the same cycle
  // as the I2C write triggered by this SCL fall.
  task automatic send_bit(input logic b, input logic coll);
    bus.sda = b;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(2 * Q);
    bus.scl = 1'b0;
    if (coll) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      hw_we = 1'b1; hw_addr = coll_addr; hw_wdata = coll_data;
      @(posedge clk);
      #1 m_regs[coll_addr] = coll_data;
      @(negedge clk);
      hw_we = 1'b0;
      wait_clk(Q - 3);
    end else begin
      wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack, input logic coll);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    bus.rx = b;
    send_bit(ack, coll);
  endtask

  task automatic i2c_start();
    if (!bus.scl) begin
      bus.sda = 1'b1; wait_clk(Q);
      bus.scl = 1'b1; wait_clk(Q);
    end
    bus.sda = 1'b0; wait_clk(Q);
    bus.scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    bus.sda = 1'b0; wait_clk(Q);
    bus.scl = 1'b1; wait_clk(Q);
    bus.sda = 1'b1; wait_clk(Q);
  endtask

  task automatic hw_write(input logic [3:0] a, input logic [7:0] d);
    hw_we = 1'b1; hw_addr = a; hw_wdata = d;
    @(posedge clk);
    #1 m_regs[a] = d;
    @(negedge clk);
    hw_we = 1'b0;
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  // Controller write: address, pointer byte, n data bytes. rw_bad makes the
  // peripheral's rw disagree with the address byte.
  task automatic write_frame(input logic [6:0] dev, input logic rw_bad, input logic [7:0] p,
                             input int n, input logic [7:0] d0, input logic [7:0] d1,
                             input logic do_stop, input logic coll);
    logic hit;
    wr_t  w;
    hit = (dev == ADDR) && !rw_bad;
    if (hit && n > 0) begin w.addr = p[3:0];        w.data = d0; exp_q.push_back(w); end
    if (hit && n > 1) begin w.addr = p[3:0] + 4'd1; w.data = d1; exp_q.push_back(w); end
    i2c_start();
    bus.rw = rw_bad;
    send_byte({dev, 1'b0}, !hit, 1'b0);
    send_byte(p, !hit, 1'b0);
    check("busy_in_frame", 32'(busy), 32'(hit));
    if (n > 0) begin send_byte(d0, !hit, coll); check("busy_in_frame", 32'(busy), 32'(hit)); end
    if (n > 1) begin send_byte(d1, !hit, 1'b0); check("busy_in_frame", 32'(busy), 32'(hit)); end
    if (do_stop) begin
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
    end
    bus.rw = 1'b0;
  endtask

  logic [7:0] rb;
  int         cnt0;

  initial begin
    rst_n = 1'b0;
    bus.scl = 1'b1; bus.sda = 1'b1; bus.rx = '0; bus.rw = 1'b0;
    hw_we = 1'b0; hw_addr = '0; hw_wdata = '0; rd_addr = '0;
    coll_addr = '0; coll_data = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    wait_clk(3);
    check("rst_tx", 32'(bus.tx), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    wait_clk(2);

    // Write with auto-increment
    write_frame(ADDR, 1'b0, 8'h03, 2, 8'hAA, 8'hBB, 1'b1, 1'b0);
    check("write_strobe_count", 32'(strobe_cnt), 32'd2);
    peek("write_reg3", 4'd3, 8'hAA);
    peek("write_reg4", 4'd4, 8'hBB);

    // Read with pointer wrap
    hw_write(4'd15, 8'h5A);
    hw_write(4'd0, 8'hC3);
    hw_write(4'd1, 8'h3C);
    write_frame(ADDR, 1'b0, 8'h0F, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    i2c_start();
    bus.rw = 1'b1;
    send_byte({ADDR, 1'b1}, 1'b0, 1'b0);
    check("read_busy", 32'(busy), 32'd1);
    check("read_tx_byte0", 32'(bus.tx), 32'h5A);
    send_byte(8'h5A, 1'b0, 1'b0);
    check("read_tx_byte1", 32'(bus.tx), 32'hC3);
    send_byte(8'hC3, 1'b1, 1'b0);
    check("read_ptr_final", 32'(bus.tx), 32'h3C);
    i2c_stop();
    bus.rw = 1'b0;

    // Wrong address and rw mismatch leave the bank untouched
    cnt0 = strobe_cnt;
    write_frame(7'h43, 1'b0, 8'h11, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    write_frame(ADDR, 1'b1, 8'h09, 1, 8'h44, 8'h00, 1'b1, 1'b0);
    check("ignore_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    peek("ignore_reg9", 4'd9, 8'h00);

    // Collisions: same address (I2C wins), then a different address
    coll_addr = 4'd5; coll_data = 8'h77;
    write_frame(ADDR, 1'b0, 8'h05, 1, 8'h99, 8'h00, 1'b1, 1'b1);
    peek("coll_same_reg5", 4'd5, 8'h99);
    coll_addr = 4'd6;
    write_frame(ADDR, 1'b0, 8'h05, 1, 8'hA5, 8'h00, 1'b1, 1'b1);
    peek("coll_diff_reg5", 4'd5, 8'hA5);
    peek("coll_diff_reg6", 4'd6, 8'h77);

    // Reset during bit 4 of a data byte
    rd_addr = 4'd5;
    rb = 8'hF0;
    i2c_start();
    send_byte({ADDR, 1'b0}, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    for (int i = 7; i >= 5; i--) send_bit(rb[i], 1'b0);
    bus.sda = rb[4];
    wait_clk(1);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    exp_q.delete();
    wait_clk(2);
    check("midrst_tx", 32'(bus.tx), 32'h00);
    check("midrst_rd_data", 32'(rd_data), 32'h00);
    check("midrst_strobe", 32'(wr_strobe), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(Q - 3);
    bus.scl = 1'b1; wait_clk(2 * Q);
    bus.scl = 1'b0; wait_clk(Q);
    cnt0 = strobe_cnt;
    for (int i = 3; i >= 0; i--) send_bit(rb[i], 1'b0);
    send_bit(1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    i2c_stop();
    check("midrst_ignored", 32'(strobe_cnt), 32'(cnt0));
    check("midrst_busy_after", 32'(busy), 32'd0);
    write_frame(ADDR, 1'b0, 8'h0A, 1, 8'h12, 8'h00, 1'b1, 1'b0);
    peek("midrst_recover_reg10", 4'd10, 8'h12);

    // STOP after 5 data bits discards the byte
    cnt0 = strobe_cnt;
    rb = 8'hE7;
    i2c_start();
    send_byte({ADDR, 1'b0}, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    for (int i = 7; i >= 3; i--) send_bit(rb[i], 1'b0);
    i2c_stop();
    check("abort_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    check("abort_busy", 32'(busy), 32'd0);
    peek("abort_reg8", 4'd8, 8'h00);
    write_frame(ADDR, 1'b0, 8'h08, 1, 8'h3E, 8'h00, 1'b1, 1'b0);
    peek("abort_recover_reg8", 4'd8, 8'h3E);

    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      wait_clk(1);
    end
    wait_clk(2);
    check("no_missing_strobes", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
